// File: rtl/inv_kin_pkg.sv
// Shared types and constants for the inverse-kinematics stimulus/capture block:
// LFSR polynomial, y-seed scrambler, FSM states and the captured record layout.
package inv_kin_pkg;

  localparam logic [31:0] LFSR_MASK  = 32'h80200003;
  localparam logic [31:0] Y_SEED_XOR = 32'hA5A5A5A5;

  typedef enum logic [2:0] {
    IDLE,
    RESET_DUT,
    DRIVE,
    SETTLE,
    CAPTURE,
    DONE
  } state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] theta1;
    logic [31:0] theta2;
  } rec_t;

  // An all-zero state would lock the LFSR, so zero seeds are promoted to 1.
  function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

endpackage

// File: rtl/inv_kin_stim_capture_fifo.sv
// stim_rec_fifo: synchronous show-ahead record FIFO; the head entry is always
// visible on dout, and a pop frees a slot for a push in the same cycle.
module stim_rec_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/inv_kin_stim_capture.sv
// Drives LFSR-generated (x, y) targets into an inv_kin DUT, waits a settle time and
// captures {x, y, theta1, theta2} records into a FIFO. STIM_RANGE_MASK_EN limits targets to 0..127.
module inv_kin_stim_capture
  import inv_kin_pkg::*;
#(
  parameter int          BIT_WIDTH      = 32,
  parameter int          FRACTIONS      = 15,
  parameter int          NUM_SAMPLES    = 1000,
  parameter int          SETTLE_CYCLES  = 500,
  parameter int          DUT_RST_CYCLES = 1,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] SEED           = 32'd7
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          sample_count,
  output logic                 dut_rst,
  output logic [BIT_WIDTH-1:0] dut_x,
  output logic [BIT_WIDTH-1:0] dut_y,
  input  logic [BIT_WIDTH-1:0] dut_theta1,
  input  logic [BIT_WIDTH-1:0] dut_theta2,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [BIT_WIDTH-1:0] rec_x,
  output logic [BIT_WIDTH-1:0] rec_y,
  output logic [BIT_WIDTH-1:0] rec_theta1,
  output logic [BIT_WIDTH-1:0] rec_theta2
);

  localparam logic [31:0]      X_SEED      = nonzero_seed(SEED);
  localparam logic [31:0]      Y_SEED      = nonzero_seed(SEED ^ Y_SEED_XOR);
  localparam logic [1:0][31:0] SEED_INIT   = {Y_SEED, X_SEED};
  localparam logic [31:0]      RST_LAST    = 32'(DUT_RST_CYCLES - 1);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      NUM_TOTAL   = 32'(NUM_SAMPLES);
  localparam int               REC_W       = 4 * BIT_WIDTH;

  if (BIT_WIDTH < 16 || BIT_WIDTH > 32) begin : g_bad_width
    $error("inv_kin_stim_capture: BIT_WIDTH must be 16..32");
  end
  if (FRACTIONS < 0 || FRACTIONS >= BIT_WIDTH) begin : g_bad_fractions
    $error("inv_kin_stim_capture: FRACTIONS must be below BIT_WIDTH");
  end
  if (NUM_SAMPLES < 1 || SETTLE_CYCLES < 1 || DUT_RST_CYCLES < 0) begin : g_bad_counts
    $error("inv_kin_stim_capture: NUM_SAMPLES and SETTLE_CYCLES must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inv_kin_stim_capture: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_e               state_q, state_d;
  logic [1:0][31:0]     lfsr_q, lfsr_d;
  logic [31:0]          lfsr_next [2];
  logic [BIT_WIDTH-1:0] target [2];
  logic [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]          count_q, count_d;
  logic [31:0]          wait_q, wait_d;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, can_push;
  logic [REC_W-1:0]     fifo_din, fifo_dout;
  rec_t                 push_rec;

  // Channel 0 is x, channel 1 is y; the target is derived from the stepped state.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lfsr
    assign lfsr_next[gi] = lfsr_step(lfsr_q[gi]);
`ifdef STIM_RANGE_MASK_EN
    logic [31:0] masked;
    assign masked      = {25'd0, lfsr_next[gi][6:0]} << FRACTIONS;
    assign target[gi]  = masked[BIT_WIDTH-1:0];
`else
    assign target[gi]  = lfsr_next[gi][BIT_WIDTH-1:0];
`endif
  end

  assign fifo_pop = ~fifo_empty & rec_ready;
  assign can_push = ~fifo_full | fifo_pop;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    wait_d    = wait_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lfsr_d  = SEED_INIT;
          count_d = '0;
          wait_d  = '0;
          state_d = (DUT_RST_CYCLES == 0) ? DRIVE : RESET_DUT;
        end
      end
      RESET_DUT: begin
        if (wait_q == RST_LAST) begin
          wait_d  = '0;
          state_d = DRIVE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      DRIVE: begin
        lfsr_d[0] = lfsr_next[0];
        lfsr_d[1] = lfsr_next[1];
        x_d       = target[0];
        y_d       = target[1];
        wait_d    = '0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (wait_q == SETTLE_LAST) begin
          wait_d  = '0;
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      CAPTURE: begin
        // A full FIFO holds us here with x/y unchanged until the consumer frees a slot.
        if (can_push) begin
          fifo_push = 1'b1;
          count_d   = count_q + 32'd1;
          state_d   = (count_q + 32'd1 == NUM_TOTAL) ? DONE : DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_INIT;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    push_rec.x      = 32'(x_q);
    push_rec.y      = 32'(y_q);
    push_rec.theta1 = 32'(dut_theta1);
    push_rec.theta2 = 32'(dut_theta2);
  end

  assign fifo_din = {push_rec.x[BIT_WIDTH-1:0], push_rec.y[BIT_WIDTH-1:0],
                     push_rec.theta1[BIT_WIDTH-1:0], push_rec.theta2[BIT_WIDTH-1:0]};

  stim_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy         = (state_q == RESET_DUT) || (state_q == DRIVE) ||
                        (state_q == SETTLE) || (state_q == CAPTURE);
  assign done         = (state_q == DONE);
  assign dut_rst      = (state_q == RESET_DUT);
  assign sample_count = count_q;
  assign dut_x        = x_q;
  assign dut_y        = y_q;
  assign rec_valid    = ~fifo_empty;
  assign rec_x        = fifo_dout[4*BIT_WIDTH-1 -: BIT_WIDTH];
  assign rec_y        = fifo_dout[3*BIT_WIDTH-1 -: BIT_WIDTH];
  assign rec_theta1   = fifo_dout[2*BIT_WIDTH-1 -: BIT_WIDTH];
  assign rec_theta2   = fifo_dout[BIT_WIDTH-1:0];

endmodule

// File: tb/tb_inv_kin_stim_capture.sv
// Bench for inv_kin_stim_capture: a long-settle single-sample instance (a) and a
// shallow-FIFO multi-sample instance (b) checked against a queue-based record model.
module tb_inv_kin_stim_capture;

  localparam logic [31:0] POLY = 32'h80200003;
`ifdef STIM_RANGE_MASK_EN
  localparam logic [31:0] A_X0 = 32'h00018000;
  localparam logic [31:0] A_Y0 = 32'h00290000;
  localparam logic [31:0] B_X0 = 32'h00000000;
  localparam logic [31:0] B_Y0 = 32'h00288000;
`else
  localparam logic [31:0] A_X0 = 32'h80200003;
  localparam logic [31:0] A_Y0 = 32'h52D2D2D2;
  localparam logic [31:0] B_X0 = 32'h80200000;
  localparam logic [31:0] B_Y0 = 32'h52D2D2D1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, start_a, busy_a, done_a, dut_rst_a, rec_valid_a, rec_ready_a;
  logic [31:0] sc_a, x_a, y_a, t1_a, t2_a, rx_a, ry_a, rt1_a, rt2_a;
  logic        rst_b, start_b, busy_b, done_b, dut_rst_b, rec_valid_b, rec_ready_b;
  logic [31:0] sc_b, x_b, y_b, t1_b, t2_b, rx_b, ry_b, rt1_b, rt2_b;

  assign t1_a = 32'h12345678;
  assign t2_a = 32'h0000ABCD;
  assign t1_b = x_b ^ 32'hFFFF0000;
  assign t2_b = y_b + 32'd1;

  inv_kin_stim_capture #(
    .BIT_WIDTH(32), .FRACTIONS(15), .NUM_SAMPLES(1), .SETTLE_CYCLES(500),
    .DUT_RST_CYCLES(1), .FIFO_DEPTH(8), .SEED(32'd1)
  ) dut_a (
    .clock(clock), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .sample_count(sc_a), .dut_rst(dut_rst_a), .dut_x(x_a), .dut_y(y_a),
    .dut_theta1(t1_a), .dut_theta2(t2_a), .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
    .rec_x(rx_a), .rec_y(ry_a), .rec_theta1(rt1_a), .rec_theta2(rt2_a)
  );

  inv_kin_stim_capture #(
    .BIT_WIDTH(32), .FRACTIONS(15), .NUM_SAMPLES(10), .SETTLE_CYCLES(2),
    .DUT_RST_CYCLES(1), .FIFO_DEPTH(4), .SEED(32'd7)
  ) dut_b (
    .clock(clock), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .sample_count(sc_b), .dut_rst(dut_rst_b), .dut_x(x_b), .dut_y(y_b),
    .dut_theta1(t1_b), .dut_theta2(t2_b), .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
    .rec_x(rx_b), .rec_y(ry_b), .rec_theta1(rt1_b), .rec_theta2(rt2_b)
  );

  int errors = 0;
  int checks = 0;
  int popped_b = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t1;
    logic [31:0] t2;
  } exp_rec_t;
  exp_rec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] s);
`ifdef STIM_RANGE_MASK_EN
    return (s % 32'd128) * 32'd32768;
`else
    return s;
`endif
  endfunction

  // Expected records of a whole run, with theta reproduced from the bench's DUT stand-in.
  task automatic build_run(input logic [31:0] seed, input int n);
    logic [31:0] xs, ys;
    exp_rec_t r;
    xs = (seed == 0) ? 32'd1 : seed;
    ys = ((seed ^ 32'hA5A5A5A5) == 0) ? 32'd1 : (seed ^ 32'hA5A5A5A5);
    for (int i = 0; i < n; i++) begin
      xs = m_next(xs);
      ys = m_next(ys);
      r.x  = m_target(xs);
      r.y  = m_target(ys);
      r.t1 = r.x ^ 32'hFFFF0000;
      r.t2 = r.y + 32'd1;
      exp_q.push_back(r);
    end
  endtask

  // Per-cycle scoreboard for instance b.
  initial begin
    forever begin
      @(negedge clock);
      if (rst_b) begin
        if (rec_valid_b && rec_ready_b) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rec_unexpected: got record x=0x%08h, required no record", rx_b);
          end else begin
            exp_rec_t e;
            e = exp_q.pop_front();
            $display("rec b#%0d x=%08h y=%08h t1=%08h t2=%08h", popped_b, rx_b, ry_b, rt1_b, rt2_b);
            chk("rec_x", rx_b, e.x);
            chk("rec_y", ry_b, e.y);
            chk("rec_theta1", rt1_b, e.t1);
            chk("rec_theta2", rt2_b, e.t2);
            popped_b++;
          end
        end
        if (done_b) chk("done_sample_count", sc_b, 32'd10);
`ifdef STIM_RANGE_MASK_EN
        if (busy_b) begin
          chk("mask_x", x_b & ~32'h003F8000, 32'd0);
          chk("mask_y", y_b & ~32'h003F8000, 32'd0);
        end
`endif
      end
    end
  end

  task automatic wait_done_b(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clock);
      #1;
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    bit ok;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rec_ready_a = 1'b1; rec_ready_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("a_reset_busy", busy_a, 0);
    chk("a_reset_done", done_a, 0);
    chk("a_reset_dut_rst", dut_rst_a, 0);
    chk("a_reset_x", x_a, 0);
    chk("a_reset_y", y_a, 0);
    chk("a_reset_count", sc_a, 0);
    chk("a_reset_valid", rec_valid_a, 0);
    chk("b_reset_valid", rec_valid_b, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clock);
    #1;

    // Instance a: one sample, 500-cycle settle
    start_a = 1'b1;
    cyc = 0;
    ok = 1'b0;
    while (cyc < 2000 && !ok) begin
      @(posedge clock);
      cyc++;
      #1;
      start_a = 1'b0;
      if (cyc == 1) begin
        chk("a_dut_rst_on", dut_rst_a, 1);
        chk("a_busy_on", busy_a, 1);
      end
      if (cyc == 2) chk("a_dut_rst_off", dut_rst_a, 0);
      if (cyc == 3) begin
        chk("a_first_x", x_a, A_X0);
        chk("a_first_y", y_a, A_Y0);
      end
      if (done_a) ok = 1'b1;
    end
    chk("a_done_seen", ok, 1);
    chk("a_run_cycles", cyc, 504);
    chk("a_rec_valid", rec_valid_a, 1);
    chk("a_rec_x", rx_a, A_X0);
    chk("a_rec_y", ry_a, A_Y0);
    chk("a_rec_theta1", rt1_a, 32'h12345678);
    chk("a_rec_theta2", rt2_a, 32'h0000ABCD);
    chk("a_count", sc_a, 1);
    chk("a_busy_off", busy_a, 0);

    // Instance b: stall with consumer blocked, then drain
    exp_q.delete();
    build_run(32'd7, 10);
    chk("model_pin_x0", exp_q[0].x, B_X0);
    chk("model_pin_y0", exp_q[0].y, B_Y0);
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    repeat (60) @(posedge clock);
    #1;
    chk("b_stall_count", sc_b, 4);
    chk("b_stall_valid", rec_valid_b, 1);
    chk("b_stall_busy", busy_b, 1);
    chk("b_stall_done", done_b, 0);
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("b_start_ignored_count", sc_b, 4);
    chk("b_start_ignored_busy", busy_b, 1);
    rec_ready_b = 1'b1;
    wait_done_b(500, ok);
    chk("b_done_seen", ok, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("b_drained", popped_b, 10);
    chk("b_model_empty", exp_q.size(), 0);
    chk("b_valid_after_drain", rec_valid_b, 0);
    chk("b_final_count", sc_b, 10);

    // Restart from DONE, then abort during the settle of sample 5
    popped_b = 0;
    build_run(32'd7, 10);
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    chk("b_restart_busy", busy_b, 1);
    chk("b_restart_done", done_b, 0);
    chk("b_restart_count", sc_b, 0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clock);
      #1;
      if (sc_b == 32'd5) ok = 1'b1;
    end
    chk("b_reach_five", ok, 1);
    @(posedge clock);
    #1;
    rst_b = 1'b0;
    #1;
    chk("b_abort_busy", busy_b, 0);
    chk("b_abort_done", done_b, 0);
    chk("b_abort_dut_rst", dut_rst_b, 0);
    chk("b_abort_x", x_b, 0);
    chk("b_abort_y", y_b, 0);
    chk("b_abort_count", sc_b, 0);
    chk("b_abort_valid", rec_valid_b, 0);
    chk("b_popped_before_abort", popped_b, 5);
    exp_q.delete();
    @(posedge clock);
    #1;
    rst_b = 1'b1;
    @(posedge clock);
    #1;
    popped_b = 0;
    build_run(32'd7, 10);
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    wait_done_b(500, ok);
    chk("b_rerun_done_seen", ok, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("b_rerun_drained", popped_b, 10);
    chk("b_rerun_model_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
